// File: rtl/bank_cmd_arbiter.sv
// Command arbiter for the AiM memory-controller scheduler.
// Picks one of 16 bank engines, the AiM engine or the refresh handler each
// cycle, acknowledges it combinationally and registers its packet/command
// toward the command/data handler (also broadcast to requesters and the
// row arbiter).
//
// Handshake: a requester holds bke_pkt_req[i] with bke_pkt[i]/bke_cmd[i]
// stable; bkarb_pkt_ack[i] is high for exactly the cycle in which it wins
// (only while its req is high and bkarb_en is high), and the requester drops
// or advances its req at the following edge. The registered outputs carry
// that winner one cycle later with bkarb_pkt_valid high.

package bank_cmd_arbiter_pkg;
  localparam int BK_ADDR_WIDTH = 4;
  localparam int NUM_BK        = 2 ** BK_ADDR_WIDTH;
  localparam int N_REQ         = NUM_BK + 2;
  localparam int AIM_IDX       = NUM_BK;
  localparam int REF_IDX       = NUM_BK + 1;
  localparam int PRIO_W        = 2;

  typedef enum logic [4:0] {
    NOP1     = 5'd0,
    NOP2     = 5'd1,
    ACT      = 5'd2,
    PREB     = 5'd3,
    PREA     = 5'd4,
    REFB     = 5'd5,
    REFA     = 5'd6,
    RD       = 5'd7,
    WR       = 5'd8,
    WDM      = 5'd9,
    AIM_MAC  = 5'd10,
    AIM_RDCP = 5'd11,
    AIM_WRCP = 5'd12
  } cmd_t;

  typedef struct packed {
    logic [PRIO_W-1:0]        prio;
    logic [BK_ADDR_WIDTH-1:0] bk_addr;
    logic [7:0]               tag;
  } pkt_meta_t;

  typedef struct packed {
    logic [6:0] rsvd;
    logic       rr_en;   // bit 0: 1 = round-robin among banks, 0 = fixed
  } cfr_schd_t;

  // Column commands move data, so the row arbiter must pull for them.
  function automatic logic is_data_cmd(input cmd_t c);
    logic r;
    case (c)
      RD, WR, WDM, AIM_MAC, AIM_RDCP, AIM_WRCP: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction
endpackage

module bank_cmd_arbiter
  import bank_cmd_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  cfr_schd_t                cfr_schd_p,
  input  pkt_meta_t                bke_pkt [N_REQ],
  input  cmd_t                     bke_cmd [N_REQ],
  input  logic [N_REQ-1:0]         bke_pkt_req,
  output logic [N_REQ-1:0]         bkarb_pkt_ack,
  input  logic                     bkarb_en,
  output pkt_meta_t                bkarb_pkt,
  output cmd_t                     bkarb_cmd,
  output logic                     bkarb_pkt_valid,
  output logic                     bkarb_pkt_ignore,
  output logic [BK_ADDR_WIDTH-1:0] dbg_rr_ptr_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         elig;
  logic [PRIO_W-1:0]        max_prio;
  logic                     any_elig;
  logic                     bank_found;
  logic [BK_ADDR_WIDTH-1:0] bank_idx;
  logic [BK_ADDR_WIDTH-1:0] scan_idx;
  logic                     grant;
  logic [IDX_W-1:0]         win_idx;

  logic                     valid_q, valid_d;
  logic                     ignore_q, ignore_d;
  pkt_meta_t                pkt_q, pkt_d;
  cmd_t                     cmd_q, cmd_d;
  logic [BK_ADDR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                     cfg_unused;
  assign cfg_unused = ^cfr_schd_p.rsvd;

  // Highest priority among eligible banks and the AiM engine.
  always_comb begin
    elig     = bke_pkt_req & {N_REQ{bkarb_en}};
    max_prio = '0;
    any_elig = 1'b0;
    for (int i = 0; i <= NUM_BK; i++) begin
      if (elig[i] && (!any_elig || (bke_pkt[i].prio > max_prio))) begin
        max_prio = bke_pkt[i].prio;
        any_elig = 1'b1;
      end
    end
  end

  // First bank at max priority, scanning from the pointer (RR) or from 0.
  always_comb begin
    bank_found = 1'b0;
    bank_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_BK; k++) begin
      scan_idx = cfr_schd_p.rr_en ? (rr_ptr_q + BK_ADDR_WIDTH'(k)) : BK_ADDR_WIDTH'(k);
      if (!bank_found && elig[scan_idx] && (bke_pkt[scan_idx].prio == max_prio)) begin
        bank_found = 1'b1;
        bank_idx   = scan_idx;
      end
    end
  end

  // Final winner: refresh first, then the bank tie-break, then AiM.
  always_comb begin
    grant   = 1'b0;
    win_idx = '0;
    if (elig[REF_IDX]) begin
      grant   = 1'b1;
      win_idx = IDX_W'(REF_IDX);
    end else if (bank_found) begin
      grant   = 1'b1;
      win_idx = IDX_W'(bank_idx);
    end else if (elig[AIM_IDX]) begin
      grant   = 1'b1;
      win_idx = IDX_W'(AIM_IDX);
    end
    bkarb_pkt_ack = grant ? (N_REQ'(1) << win_idx) : '0;
  end

  // Next values of the output registers and the round-robin pointer.
  always_comb begin
    valid_d  = grant;
    ignore_d = 1'b0;
    pkt_d    = pkt_q;
    cmd_d    = cmd_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      pkt_d    = bke_pkt[win_idx];
      cmd_d    = bke_cmd[win_idx];
      ignore_d = (win_idx == IDX_W'(REF_IDX)) || !is_data_cmd(bke_cmd[win_idx]);
      if (cfr_schd_p.rr_en && (win_idx < IDX_W'(NUM_BK))) begin
        rr_ptr_d = bank_idx + BK_ADDR_WIDTH'(1);
      end
    end
  end

  // Output and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ignore_q <= 1'b0;
      pkt_q    <= '0;
      cmd_q    <= NOP1;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ignore_q <= ignore_d;
      pkt_q    <= pkt_d;
      cmd_q    <= cmd_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bkarb_pkt        = pkt_q;
  assign bkarb_cmd        = cmd_q;
  assign bkarb_pkt_valid  = valid_q;
  assign bkarb_pkt_ignore = ignore_q;
  assign dbg_rr_ptr_o     = rr_ptr_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed scenarios plus randomized traffic
// checked against a priority/distance reference model.
module tb_bank_cmd_arbiter;
  import bank_cmd_arbiter_pkg::*;

  localparam int W = 2 + $bits(pkt_meta_t) + $bits(cmd_t);

  logic                     clk = 1'b0;
  logic                     rst;
  cfr_schd_t                cfg;
  pkt_meta_t                pkt [N_REQ];
  cmd_t                     cmd [N_REQ];
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         ack;
  logic                     en;
  pkt_meta_t                o_pkt;
  cmd_t                     o_cmd;
  logic                     o_valid;
  logic                     o_ignore;
  logic [BK_ADDR_WIDTH-1:0] dbg_ptr;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           m_ptr;
  pkt_meta_t    m_pkt;
  cmd_t         m_cmd;

  bank_cmd_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .cfr_schd_p       (cfg),
    .bke_pkt          (pkt),
    .bke_cmd          (cmd),
    .bke_pkt_req      (req),
    .bkarb_pkt_ack    (ack),
    .bkarb_en         (en),
    .bkarb_pkt        (o_pkt),
    .bkarb_cmd        (o_cmd),
    .bkarb_pkt_valid  (o_valid),
    .bkarb_pkt_ignore (o_ignore),
    .dbg_rr_ptr_o     (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic bit is_col_cmd(input cmd_t c);
    return c inside {RD, WR, WDM, AIM_MAC, AIM_RDCP, AIM_WRCP};
  endfunction

  // Reference winner: refresh, else highest prio; among banks at that prio
  // the smallest distance from the pointer (RR) or the smallest index.
  function automatic int model_winner();
    int maxp   = -1;
    int best   = -1;
    int best_d = NUM_BK;
    int d;
    if (!en) return -1;
    if (req[REF_IDX]) return REF_IDX;
    for (int i = 0; i <= NUM_BK; i++)
      if (req[i] && int'(pkt[i].prio) > maxp) maxp = int'(pkt[i].prio);
    if (maxp < 0) return -1;
    for (int i = 0; i < NUM_BK; i++) begin
      if (req[i] && int'(pkt[i].prio) == maxp) begin
        d = cfg.rr_en ? ((i - m_ptr + NUM_BK) % NUM_BK) : i;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    if (best >= 0) return best;
    return AIM_IDX;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_pkt = '0;
    m_cmd = NOP1;
    exp_q.delete();
  endtask

  // Computes this cycle's expected ack and queues the registered outputs
  // expected after the coming edge.
  task automatic predict(output logic [N_REQ-1:0] exp_ack);
    int w;
    logic [W-1:0] e;
    w = model_winner();
    exp_ack = '0;
    if (w >= 0) begin
      exp_ack[w] = 1'b1;
      m_pkt = pkt[w];
      m_cmd = cmd[w];
      e = {1'b1, (w == REF_IDX) || !is_col_cmd(cmd[w]), m_pkt, m_cmd};
      if (w < NUM_BK && cfg.rr_en) m_ptr = (w + 1) % NUM_BK;
    end else begin
      e = {2'b00, m_pkt, m_cmd};
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pkt[i] = '{prio: 2'd0, bk_addr: BK_ADDR_WIDTH'(i), tag: 8'(i)};
      cmd[i] = RD;
    end
    cmd[AIM_IDX] = AIM_MAC;
    cmd[REF_IDX] = REFA;
  endtask

  task automatic test_reset();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    rst = 1'b1;
    en  = 1'b1;
    cfg = '{rsvd: 7'd0, rr_en: 1'b1};
    clear_inputs();
    model_reset();
    repeat (2) tick();
    checks++;
    if ({o_valid, o_ignore, o_pkt, o_cmd} !== {2'b00, {$bits(pkt_meta_t){1'b0}}, NOP1}) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", {o_valid, o_ignore, o_pkt, o_cmd},
               {2'b00, {$bits(pkt_meta_t){1'b0}}, NOP1});
    end
    checks++;
    if (dbg_ptr !== '0) begin
      failures++;
      $display("FAIL reset_ptr: got %0d expected 0", dbg_ptr);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== '0) begin
        failures++;
        $display("FAIL idle_ack: cycle %0d got %h expected 0", k, ack);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b0 || o_cmd !== NOP1 || {o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL idle_out: cycle %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
    end
  endtask

  task automatic test_rr_pair();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    int b;
    clear_inputs();
    req[3] = 1'b1;
    req[7] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b = (k % 2 == 0) ? 3 : 7;
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== (N_REQ'(1) << b)) begin
        failures++;
        $display("FAIL rr_ack: cycle %0d got %h expected %h", k, ack, N_REQ'(1) << b);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || o_pkt.bk_addr !== BK_ADDR_WIDTH'(b) || {o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL rr_out: cycle %0d got %h expected %h bank %0d", k, {o_valid, o_ignore, o_pkt, o_cmd}, e, b);
      end
    end
    req = '0;
  endtask

  task automatic test_prio();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    clear_inputs();
    req[5] = 1'b1;
    req[9] = 1'b1;
    pkt[9].prio = 2'd2;
    for (int k = 0; k < 2; k++) begin
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== (N_REQ'(1) << ((k == 0) ? 9 : 5))) begin
        failures++;
        $display("FAIL prio_ack: step %0d got %h expected %h", k, ack, N_REQ'(1) << ((k == 0) ? 9 : 5));
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_pkt.bk_addr !== BK_ADDR_WIDTH'((k == 0) ? 9 : 5) || {o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL prio_out: step %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
      req[9] = 1'b0;
    end
    req = '0;
  endtask

  task automatic test_ref_aim();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    clear_inputs();
    req[REF_IDX] = 1'b1;
    req[AIM_IDX] = 1'b1;
    pkt[AIM_IDX].prio = 2'd3;
    for (int k = 0; k < 2; k++) begin
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== (N_REQ'(1) << ((k == 0) ? REF_IDX : AIM_IDX))) begin
        failures++;
        $display("FAIL ref_aim_ack: step %0d got %h expected %h", k, ack,
                 N_REQ'(1) << ((k == 0) ? REF_IDX : AIM_IDX));
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_ignore !== (k == 0) || o_valid !== 1'b1 || {o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL ref_aim_out: step %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
      req[REF_IDX] = 1'b0;
    end
    req = '0;
    checks++;
    if (dbg_ptr !== BK_ADDR_WIDTH'(6)) begin
      failures++;
      $display("FAIL ref_aim_ptr: got %0d expected 6", dbg_ptr);
    end
  endtask

  task automatic test_enable();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    clear_inputs();
    en = 1'b0;
    req[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) en = 1'b1;
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== ((k == 5) ? (N_REQ'(1) << 2) : '0)) begin
        failures++;
        $display("FAIL en_ack: step %0d got %h expected %h", k, ack, (k == 5) ? (N_REQ'(1) << 2) : '0);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_valid !== (k == 5) || {o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL en_out: step %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
    end
    req = '0;
  endtask

  task automatic test_fixed_reset();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    clear_inputs();
    cfg.rr_en = 1'b0;
    req[1] = 1'b1;
    req[4] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req[1] = 1'b0;
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== (N_REQ'(1) << ((k < 4) ? 1 : 4))) begin
        failures++;
        $display("FAIL fixed_ack: step %0d got %h expected %h", k, ack, N_REQ'(1) << ((k < 4) ? 1 : 4));
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL fixed_out: step %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
    end
    checks++;
    if (dbg_ptr !== BK_ADDR_WIDTH'(3)) begin
      failures++;
      $display("FAIL fixed_ptr_hold: got %0d expected 3", dbg_ptr);
    end
    req[1] = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (o_valid !== 1'b0 || o_cmd !== NOP1 || o_pkt !== '0 || dbg_ptr !== '0) begin
      failures++;
      $display("FAIL midreset: got valid %b cmd %0d pkt %h ptr %0d expected 0/NOP1/0/0",
               o_valid, o_cmd, o_pkt, dbg_ptr);
    end
    tick();
    rst = 1'b0;
    #1;
    predict(exp_ack);
    checks++;
    if (ack !== (N_REQ'(1) << 1)) begin
      failures++;
      $display("FAIL post_reset_ack: got %h expected %h", ack, N_REQ'(1) << 1);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
      failures++;
      $display("FAIL post_reset_out: got %h expected %h", {o_valid, o_ignore, o_pkt, o_cmd}, e);
    end
    req = '0;
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] exp_ack;
    logic [W-1:0] e;
    for (int k = 0; k < 400; k++) begin
      if (k % 100 == 0) cfg.rr_en = (k / 100) % 2 == 0;
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        pkt[i].prio = 2'($urandom_range(0, 3));
        pkt[i].tag  = 8'($urandom_range(0, 255));
        cmd[i]      = cmd_t'($urandom_range(0, 12));
        req[i]      = (i == REF_IDX) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      end
      #1;
      predict(exp_ack);
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL rand_ack: cycle %0d got %h expected %h", k, ack, exp_ack);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({o_valid, o_ignore, o_pkt, o_cmd} !== e) begin
        failures++;
        $display("FAIL rand_out: cycle %0d got %h expected %h", k, {o_valid, o_ignore, o_pkt, o_cmd}, e);
      end
      checks++;
      if (dbg_ptr !== BK_ADDR_WIDTH'(m_ptr)) begin
        failures++;
        $display("FAIL rand_ptr: cycle %0d got %0d expected %0d", k, dbg_ptr, m_ptr);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_rr_pair();
    test_prio();
    test_ref_aim();
    test_enable();
    test_fixed_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_cmd_arbiter.md
Name: bank_cmd_arbiter

Overview:
- Single-output command arbiter of the AiM memory-controller scheduler.
- Each cycle it selects one request among 16 bank engines, the AiM engine and the refresh handler.
- It acknowledges the winner and drives the registered winning packet metadata and command to the command/data handler.
- Its outputs are also broadcast back to all requesters and to the row arbiter, which uses them for data pulls.

Parameters:
- NUM_BK, 16 (2**BK_ADDR_WIDTH): number of bank-engine requesters.
- N_REQ, NUM_BK+2: total requesters. Index map: 0..NUM_BK-1 banks, NUM_BK = AiM engine, NUM_BK+1 = refresh handler.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfr_schd_p  in  $bits(cfr_schd_t)  scheduler config. Bit 0: 1 = round-robin among banks, 0 = fixed lowest-index-first.
- bke_pkt  in  N_REQ x pkt_meta_t  per-requester packet; bits 0..NUM_BK-1 banks, then AiM, then refresh.
- bke_cmd  in  N_REQ x cmd_t  per-requester command, in sync with bke_pkt.
- bke_pkt_req  in  N_REQ  request flags.
- bkarb_pkt_ack  out  N_REQ  one-hot grant acknowledge, combinational.
- bkarb_en  in  1  arbitration enable (cal_done && intf_rdy).
- bkarb_pkt  out  pkt_meta_t  registered winning packet.
- bkarb_cmd  out  cmd_t  registered winning command.
- bkarb_pkt_valid  out  1  registered valid.
- bkarb_pkt_ignore  out  1  registered: the row arbiter must not pull data for this grant.

Behaviour:
- Reset values: bkarb_pkt_valid=0, bkarb_pkt_ignore=0, bkarb_pkt=0, bkarb_cmd=NOP1, round-robin pointer=0.
- Eligible set: req[i]=1 and bkarb_en=1. If bkarb_en=0, all acks are 0, no grant occurs, and the pointer holds.
- Winner selection, in order:
  - (1) Refresh handler, if requesting, always wins.
  - (2) Otherwise, requesters with the largest pkt.prio value.
  - (3) Tie among banks: round-robin mode picks the first requesting bank at or after the pointer, wrapping NUM_BK-1 to 0. Fixed mode picks the lowest index.
  - (4) AiM engine wins a tie only when no bank with equal prio requests. A higher-prio AiM request beats banks.
- Grant handshake:
  - bkarb_pkt_ack[w] is asserted combinationally in the grant cycle, exactly one-hot, and is never asserted without a matching req.
  - The requester deasserts or advances req at the next edge.
  - A requester holding req gets no implicit grant in a later cycle without a fresh arbitration.
- Output registration, at the edge ending the grant cycle:
  - bkarb_pkt <= bke_pkt[w], bkarb_cmd <= bke_cmd[w], bkarb_pkt_valid <= 1.
  - Grant-to-output latency is 1 cycle. Back-to-back grants every cycle are allowed.
- No-grant cycle: bkarb_pkt_valid <= 0, bkarb_pkt_ignore <= 0; bkarb_pkt and bkarb_cmd hold their previous values.
- bkarb_pkt_ignore <= 1 when the winner is the refresh handler, or when the winning cmd is a non-data command (ACT, PRE variants, REF variants, NOP variants). It is 0 for column data commands (RD, WR, WDM, AiM column ops).
- Round-robin pointer: on a bank grant w it becomes (w+1) mod NUM_BK. It is unchanged on AiM or refresh grants and in fixed mode.
- Mid-operation reset clears all registers immediately; acks drop as soon as req/en inputs do.
- Purely combinational selection. Outputs carry no combinational path from inputs, except bkarb_pkt_ack.

Test Plan:
- Reset, no requests, en=1: valid=0, ack=0, cmd=NOP1, and all stay so for 10 cycles.
- Banks 3 and 7 request continuously, equal prio=0, RR mode, en=1: acks 3,7,3,7… each for one cycle; bkarb_pkt.bk_addr follows one cycle later with valid=1.
- Bank 5 prio=0 and bank 9 prio=2 request together: ack[9] first; ack[5] next cycle once bank 9 drops req.
- Refresh (REF, prio 0) and AiM engine (prio 3) request together: refresh acked first and ignore=1 next cycle; then AiM acked, with ignore=0 for a column command.
- Bank 2 requests with en=0 for 5 cycles: no ack, valid=0. Raise en: ack[2] in that cycle, valid=1 one cycle later.
- Fixed mode (cfr_schd_p[0]=0), banks 1 and 4 requesting repeatedly: bank 1 always wins until it drops req. Assert rst mid-stream: valid=0, cmd=NOP1, pointer=0.
